change_dispenser: RTL

Output-side counterpart of the vending coin-input path. The vendor logic reports a change amount in BCD. This block breaks that amount into a greedy sequence of coin-eject pulses (quarter, dime, nickel) to drive the coin-hopper solenoids. Each pulse is timed in slow-clock ticks. The coin codes on the eject bus are the same one-hot codes used by the coin buttons on the input side.

---
 rtl/vending_pkg.sv | 32 +++
 rtl/change_dispenser_tick_timer.sv | 28 ++
 rtl/change_dispenser.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared vending types: coin eject codes, coin values in nickels,
// and the change-dispenser state encoding.
package vending_pkg;

  typedef logic [2:0] coin_t;

  localparam coin_t COIN_NONE    = 3'd0;
  localparam coin_t COIN_QUARTER = 3'd4;
  localparam coin_t COIN_DIME    = 3'd2;
  localparam coin_t COIN_NICKEL  = 3'd1;

  localparam int UNITS_W = 5;
  typedef logic [UNITS_W-1:0] units_t;

  localparam units_t VAL_QUARTER = 5'd5;
  localparam units_t VAL_DIME    = 5'd2;
  localparam units_t VAL_NICKEL  = 5'd1;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    GAP,
    DONE
  } disp_state_t;

  typedef struct packed {
    coin_t  coin;
    units_t value;
  } coin_pick_t;

endpackage

// File: rtl/change_dispenser_tick_timer.sv
// Enable-tick counter with restart and terminal-count flag.
// Shared by the pulse and gap phases of the dispenser.
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         start,
  input  logic         enable,
  input  logic [W-1:0] term,
  output logic         hit
);

  logic [W-1:0] count;

  assign hit = enable && (count == term);

  always_ff @(posedge clock) begin
    if (!clear) begin
      count <= '0;
    end else if (start || hit) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change payout: turns a BCD change amount into timed
// quarter/dime/nickel eject pulses for the hopper solenoids.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int PULSE_TICKS = 2,
  parameter int GAP_TICKS   = 1
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       enable,
  input  logic       change_valid,
  input  logic [7:0] change_bcd,
  output logic       change_ready,
  output logic [2:0] eject,
  output logic [7:0] remaining,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int TW = 8;
  localparam logic [TW-1:0] PULSE_TERM = TW'(PULSE_TICKS - 1);
  localparam logic [TW-1:0] GAP_TERM   = TW'(GAP_TICKS - 1);

  disp_state_t state;
  units_t      units;
  coin_pick_t  pick;

  logic [3:0]    req_tens;
  logic [3:0]    req_ones;
  logic          req_ok;
  units_t        req_units;

  logic          tmr_run;
  logic          tmr_start;
  logic          tmr_hit;
  logic [TW-1:0] tmr_term;

  assign req_tens  = change_bcd[7:4];
  assign req_ones  = change_bcd[3:0];
  assign req_ok    = (req_tens <= 4'd9) &&
                     (req_ones == 4'd0 || req_ones == 4'd5);
  assign req_units = {req_tens, 1'b0} +
                     {4'd0, req_ones == 4'd5};

  // Units are nickels, so a dime is 2 and the tens digit is units/2.
  assign remaining = {units[4:1], units[0] ? 4'h5 : 4'h0};

  assign change_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  always_comb begin
    pick = '{coin: COIN_NICKEL, value: VAL_NICKEL};
    priority case (1'b1)
      (units >= VAL_QUARTER):
        pick = '{coin: COIN_QUARTER, value: VAL_QUARTER};
      (units >= VAL_DIME):
        pick = '{coin: COIN_DIME, value: VAL_DIME};
      default:
        pick = '{coin: COIN_NICKEL, value: VAL_NICKEL};
    endcase
  end

  assign tmr_run   = enable && (state == PULSE || state == GAP);
  assign tmr_start = (state == SELECT);
  assign tmr_term  = (state == GAP) ? GAP_TERM : PULSE_TERM;

  tick_timer #(
    .W(TW)
  ) u_timer (
    .clock  (clock),
    .clear  (clear),
    .start  (tmr_start),
    .enable (tmr_run),
    .term   (tmr_term),
    .hit    (tmr_hit)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= IDLE;
      units <= '0;
      eject <= COIN_NONE;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (change_valid) begin
            if (req_ok) begin
              units <= req_units;
              state <= SELECT;
            end else begin
              error <= 1'b1;
            end
          end
        end
        SELECT: begin
          if (units == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            eject <= pick.coin;
            units <= units - pick.value;
            state <= PULSE;
          end
        end
        PULSE: begin
          if (tmr_hit) begin
            eject <= COIN_NONE;
            state <= GAP;
          end
        end
        GAP: begin
          if (tmr_hit) begin
            state <= SELECT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          eject <= COIN_NONE;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
